// File: rtl/row_wr_512b_to_bram_if.sv
// Requester and BRAM-controller signals of the 512-bit row writer.
// master = requester/BRAM-controller side, slave = the row writer itself.
interface row_wr_512b_to_bram_if;
  logic         i_trig_wr;
  logic [8:0]   i_row_num_to_write;
  logic [511:0] i_row_512b;
  logic         o_done;
  logic         o_busy;
  logic         o_err;
  logic [12:0]  o_wr_to_bram_addr;
  logic [31:0]  o_wr_to_bram_data;
  logic         o_wr_to_bram_trig;
  logic         i_wr_to_bram_done;

  modport master (
    output i_trig_wr, i_row_num_to_write, i_row_512b, i_wr_to_bram_done,
    input  o_done, o_busy, o_err, o_wr_to_bram_addr, o_wr_to_bram_data, o_wr_to_bram_trig
  );

  modport slave (
    input  i_trig_wr, i_row_num_to_write, i_row_512b, i_wr_to_bram_done,
    output o_done, o_busy, o_err, o_wr_to_bram_addr, o_wr_to_bram_data, o_wr_to_bram_trig
  );
endinterface

// File: rtl/row_wr_512b_to_bram.sv
// Splits a captured 512-bit row into 16 ordered 32-bit BRAM writes, one strobe per word.
// First strobe the cycle after the trigger edge; each word waits for the controller's done pulse or a timeout.
module row_wr_512b_to_bram #(
  parameter int TIMEOUT_CYC = 255
) (
  input logic                   i_clk,
  input logic                   i_rstn,
  row_wr_512b_to_bram_if.slave  bus
);

  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           trig_prev;
  logic [8:0]     row_q;
  logic [511:0]   row_dat_q;
  logic [3:0]     k_q;
  logic [CW-1:0]  to_cnt;
  logic           err_q;

  logic           trig_edge;
  logic           cap_en;
  logic           k_inc;
  logic           set_err;

  assign trig_edge = bus.i_trig_wr & ~trig_prev;

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    k_inc     = 1'b0;
    set_err   = 1'b0;
    case (state)
      IDLE: begin
        if (trig_edge) begin
          cap_en    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // A done arriving on the last timeout cycle still counts as success.
        if (bus.i_wr_to_bram_done) begin
          if (k_q == 4'd15) begin
            state_nxt = DONE;
          end else begin
            k_inc     = 1'b1;
            state_nxt = ISSUE;
          end
        end else if (to_cnt == TO_LAST) begin
          set_err   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (!bus.i_trig_wr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      trig_prev <= 1'b0;
      row_q     <= '0;
      row_dat_q <= '0;
      k_q       <= '0;
      to_cnt    <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nxt;
      trig_prev <= bus.i_trig_wr;
      if (cap_en) begin
        row_q     <= bus.i_row_num_to_write;
        row_dat_q <= bus.i_row_512b;
        k_q       <= '0;
        err_q     <= 1'b0;
      end
      if (k_inc) k_q <= k_q + 4'd1;
      if (set_err) err_q <= 1'b1;
      if (state == ISSUE) begin
        to_cnt <= '0;
      end else if (state == WAIT) begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign bus.o_wr_to_bram_trig = (state == ISSUE);
  assign bus.o_busy            = (state != IDLE);
  assign bus.o_done            = (state == DONE);
  assign bus.o_err             = err_q;
  assign bus.o_wr_to_bram_addr = {row_q, k_q};
  assign bus.o_wr_to_bram_data = row_dat_q[{k_q, 5'd0} +: 32];

endmodule

// File: tb/tb_row_wr_512b_to_bram.sv
// Scoreboarded bench for row_wr_512b_to_bram with a one-cycle-latency BRAM controller model.
module tb_row_wr_512b_to_bram;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  row_wr_512b_to_bram_if bus();

  row_wr_512b_to_bram #(.TIMEOUT_CYC(8)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  typedef struct packed {
    logic [12:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_checks = 0;
  int  n_fail = 0;
  int  trig_cnt = 0;
  int  word_idx = 0;
  int  withhold_k = -1;
  bit  pend = 1'b0;
  bit  inject = 1'b0;

  // BRAM controller model: checks each strobe against the scoreboard, answers one cycle later.
  initial begin
    wr_t exp;
    bus.i_wr_to_bram_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_wr_to_bram_trig === 1'b1) begin
        trig_cnt++;
        if (word_idx != withhold_k) pend = 1'b1;
        word_idx++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_trig: got addr=%h data=%h, required no write", bus.o_wr_to_bram_addr, bus.o_wr_to_bram_data);
        end else begin
          exp = sb.pop_front();
          if ({bus.o_wr_to_bram_addr, bus.o_wr_to_bram_data} !== exp) begin
            n_fail++;
            $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h", bus.o_wr_to_bram_addr, bus.o_wr_to_bram_data, exp.addr, exp.data);
          end
        end
      end
      @(posedge clk);
      #1;
      bus.i_wr_to_bram_done = pend | inject;
      pend = 1'b0;
      inject = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic start_row(input logic [8:0] row, input logic [31:0] base, input int nexp);
    wr_t e;
    bus.i_row_num_to_write = row;
    for (int k = 0; k < 16; k++) begin
      bus.i_row_512b[k*32 +: 32] = base + 32'(k);
      if (k < nexp) begin
        e.addr = {row, k[3:0]};
        e.data = base + 32'(k);
        sb.push_back(e);
      end
    end
    word_idx = 0;
    bus.i_trig_wr = 1'b1;
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output bit ok);
    cyc = 0;
    ok = 1'b0;
    while (!ok && cyc < max_cyc) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.o_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.i_trig_wr = 1'b0;
    bus.i_row_num_to_write = '0;
    bus.i_row_512b = '0;
    #2;
    n_checks++;
    if ({bus.o_done, bus.o_busy, bus.o_err, bus.o_wr_to_bram_trig} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_status: got done/busy/err/trig=%b, required 0000", {bus.o_done, bus.o_busy, bus.o_err, bus.o_wr_to_bram_trig});
    end
    n_checks++;
    if ({bus.o_wr_to_bram_addr, bus.o_wr_to_bram_data} !== 45'd0) begin
      n_fail++;
      $display("FAIL reset_bus: got addr=%h data=%h, required 0", bus.o_wr_to_bram_addr, bus.o_wr_to_bram_data);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_row();
    int cyc, t0, hi;
    bit ok;
    t0 = trig_cnt;
    start_row(9'h00B, 32'hA5A50000, 16);
    wait_done(100, cyc, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_done_seen: got no o_done in 100 cycles, required o_done"); end
    n_checks++;
    if (cyc != 33) begin n_fail++; $display("FAIL single_latency: got %0d cycles, required 33", cyc); end
    n_checks++;
    if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b, required 0", bus.o_err); end
    hi = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.o_done === 1'b1) hi++;
    end
    #1;
    n_checks++;
    if (hi != 5) begin n_fail++; $display("FAIL hold_done_high: got %0d of 5 cycles, required 5", hi); end
    n_checks++;
    if (trig_cnt - t0 != 16) begin n_fail++; $display("FAIL hold_trig_count: got %0d, required 16", trig_cnt - t0); end
    bus.i_trig_wr = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.o_done, bus.o_busy} !== 2'b00) begin n_fail++; $display("FAIL hold_release: got done/busy=%b, required 00", {bus.o_done, bus.o_busy}); end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL single_sb_empty: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    int cyc, t0;
    bit ok;
    t0 = trig_cnt;
    start_row(9'h00B, 32'hA5A50000, 16);
    wait_done(100, cyc, ok);
    bus.i_trig_wr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!ok || bus.o_done !== 1'b0) begin n_fail++; $display("FAIL b2b_row_b: got ok=%b done=%b, required ok=1 done=0", ok, bus.o_done); end
    repeat (5) @(negedge clk);
    start_row(9'h00C, 32'h5A5A0000, 16);
    repeat (5) @(negedge clk);
    bus.i_row_num_to_write = 9'h155;
    bus.i_row_512b = {16{32'hDEADBEEF}};
    bus.i_trig_wr = 1'b0;
    wait_done(100, cyc, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL b2b_row_c_done: got no o_done, required completion despite trig drop"); end
    @(negedge clk);
    n_checks++;
    if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_pulse: got done=%b on 2nd cycle, required 0", bus.o_done); end
    #1;
    n_checks++;
    if (trig_cnt - t0 != 32) begin n_fail++; $display("FAIL b2b_trig_count: got %0d, required 32", trig_cnt - t0); end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_sb_empty: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_timeout();
    int cyc, t0, waitc;
    bit seen4, done_seen;
    t0 = trig_cnt;
    withhold_k = 3;
    @(negedge clk);
    start_row(9'h00D, 32'h3C3C0000, 4);
    cyc = 0; waitc = 0; seen4 = 1'b0; done_seen = 1'b0;
    while (!done_seen && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      #1;
      if (seen4 && bus.o_busy && !bus.o_wr_to_bram_trig && !bus.o_done) waitc++;
      if (trig_cnt - t0 == 4) seen4 = 1'b1;
      if (bus.o_done === 1'b1) done_seen = 1'b1;
    end
    n_checks++;
    if (!done_seen) begin n_fail++; $display("FAIL timeout_done: got no o_done, required o_done"); end
    n_checks++;
    if (waitc != 8) begin n_fail++; $display("FAIL timeout_wait_cycles: got %0d, required 8", waitc); end
    n_checks++;
    if (bus.o_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b, required 1", bus.o_err); end
    n_checks++;
    if (trig_cnt - t0 != 4) begin n_fail++; $display("FAIL timeout_trig_count: got %0d, required 4", trig_cnt - t0); end
    bus.i_trig_wr = 1'b0;
    withhold_k = -1;
    @(negedge clk);
    n_checks++;
    if ({bus.o_done, bus.o_err} !== 2'b01) begin n_fail++; $display("FAIL timeout_err_hold: got done/err=%b, required 01", {bus.o_done, bus.o_err}); end
  endtask

  task automatic test_spurious_done();
    int cyc, t0;
    bit ok;
    t0 = trig_cnt;
    inject = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (trig_cnt != t0 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL idle_spurious: got trigs=%0d busy=%b, required 0 and 0", trig_cnt - t0, bus.o_busy); end
    @(negedge clk);
    start_row(9'h001, 32'h0F0F0000, 16);
    inject = 1'b1;
    wait_done(100, cyc, ok);
    n_checks++;
    if (!ok || cyc != 33) begin n_fail++; $display("FAIL issue_spurious_latency: got ok=%b cycles=%0d, required 1 and 33", ok, cyc); end
    n_checks++;
    if (bus.o_err !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_accept: got %b, required 0", bus.o_err); end
    bus.i_trig_wr = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (trig_cnt - t0 != 16) begin n_fail++; $display("FAIL spurious_trig_count: got %0d, required 16", trig_cnt - t0); end
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL spurious_sb_empty: got %0d left, required 0", sb.size()); end
  endtask

  task automatic test_reset_mid();
    int cyc, t0, n;
    bit ok;
    t0 = trig_cnt;
    @(negedge clk);
    start_row(9'h00E, 32'h11110000, 16);
    n = 0;
    while (trig_cnt - t0 < 7 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    rstn = 1'b0;
    #1;
    n_checks++;
    if ({bus.o_done, bus.o_busy, bus.o_err, bus.o_wr_to_bram_trig, bus.o_wr_to_bram_addr, bus.o_wr_to_bram_data} !== 49'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got status=%b addr=%h data=%h, required all 0", {bus.o_done, bus.o_busy, bus.o_err, bus.o_wr_to_bram_trig}, bus.o_wr_to_bram_addr, bus.o_wr_to_bram_data);
    end
    sb.delete();
    bus.i_trig_wr = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    n_checks++;
    if (trig_cnt - t0 != 7 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got trigs=%0d busy=%b, required 7 and 0", trig_cnt - t0, bus.o_busy); end
    @(negedge clk);
    rstn = 1'b0;
    start_row(9'h1FF, 32'h7E7E0000, 16);
    @(negedge clk);
    rstn = 1'b1;
    wait_done(100, cyc, ok);
    n_checks++;
    if (!ok || cyc != 33) begin n_fail++; $display("FAIL release_edge_row: got ok=%b cycles=%0d, required 1 and 33", ok, cyc); end
    bus.i_trig_wr = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (trig_cnt - t0 != 23 || sb.size() != 0) begin n_fail++; $display("FAIL row_1ff_writes: got trigs=%0d left=%0d, required 23 and 0", trig_cnt - t0, sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single_row();
    repeat (4) @(negedge clk);
    test_back_to_back();
    repeat (3) @(negedge clk);
    test_timeout();
    repeat (3) @(negedge clk);
    test_spurious_done();
    repeat (3) @(negedge clk);
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/row_wr_512b_to_bram.md
ROW_WR_512B_TO_BRAM -- requirements
Module: row_wr_512b_to_bram

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, max cycles waited in WAIT for i_wr_to_bram_done per word.
REQ-002 SHALL have port i_clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port i_rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_trig_wr  input  1  level request; held high by requester until o_done seen.
REQ-005 SHALL have port i_row_num_to_write  input  9  destination row number.
REQ-006 SHALL have port i_row_512b  input  512  row payload; word k = bits [32k+31:32k].
REQ-007 SHALL have port o_done  output  1  row write finished; held until i_trig_wr low.
REQ-008 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port o_err  output  1  last row aborted on timeout; valid while o_done high.
REQ-010 SHALL have port o_wr_to_bram_addr  output  13  word address {row, k[3:0]}.
REQ-011 SHALL have port o_wr_to_bram_data  output  32  word data.
REQ-012 SHALL have port o_wr_to_bram_trig  output  1  one-cycle write strobe to top BRAM wr controller.
REQ-013 SHALL have port i_wr_to_bram_done  input  1  one-cycle completion pulse from BRAM wr controller.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-015 IDLE: on rising edge of i_trig_wr (high now, low previous cycle) SHALL capture i_row_num_to_write and i_row_512b into shadow regs, clear k and o_err, go to ISSUE.
REQ-016 Trigger SHALL be edge-qualified; i_trig_wr held high after DONE SHALL NOT restart a write.
REQ-017 ISSUE: SHALL drive o_wr_to_bram_trig=1 for exactly one cycle, addr={row,k}, data=shadow word k; next state WAIT.
REQ-018 addr and data SHALL stay stable from ISSUE until done is accepted in WAIT.
REQ-019 WAIT: i_wr_to_bram_done=1 with k<15 SHALL increment k and go to ISSUE next cycle; with k=15 SHALL go to DONE.
REQ-020 i_wr_to_bram_done SHALL be ignored in IDLE, ISSUE and DONE.
REQ-021 WAIT: timeout counter SHALL reset on entry; reaching TIMEOUT_CYC without done SHALL set o_err=1 and go to DONE, skipping remaining words.
REQ-022 Words SHALL be written in order k=0..15; exactly 16 trig pulses per successful row.
REQ-023 Latency: first trig in cycle after trigger edge sampled; with done returned L cycles after trig, each word costs 1+L cycles; o_done rises cycle after last done.
REQ-024 DONE: o_done=1; when i_trig_wr=0 sampled, o_done SHALL drop next cycle and FSM go to IDLE.
REQ-025 If i_trig_wr already low on DONE entry, o_done SHALL be high exactly one cycle.
REQ-026 i_trig_wr falling mid-transfer SHALL NOT abort; row completes.
REQ-027 Changes on i_row_512b / i_row_num_to_write after capture SHALL NOT affect the transfer.
REQ-028 o_err SHALL hold until next accepted trigger.

Reset
REQ-029 i_rstn=0 SHALL asynchronously force IDLE, k=0, counters 0, shadow regs 0, all outputs 0.
REQ-030 Reset mid-transfer SHALL discard the row; no trig pulse until a new trigger edge after release.
REQ-031 Trigger edge detector SHALL reset to "previous=0"; i_trig_wr high at reset release SHALL count as an edge on first clock.

Verification
REQ-032 Row 0x00B, payload word k=0xA5A50000+k, BRAM model done 1 cycle after trig -> 16 trigs, addr 0x00B0..0x00BF, data match, o_done rises 33 cycles after trigger edge, o_err=0.
REQ-033 Requester holds i_trig_wr high 5 cycles past o_done -> o_done high until trig low, no second row (trig count stays 16).
REQ-034 Back-to-back rows 0x00B then 0x00C (trig re-raised 5 cycles after o_done fall) -> addresses 0x00B0..0x00BF then 0x00C0..0x00CF, correct data both rows.
REQ-035 BRAM model withholds done on word 3 with TIMEOUT_CYC=8 -> 4 trigs total, o_done with o_err=1, 8 cycles WAIT on word 3.
REQ-036 Reset asserted after 7th trig -> all outputs 0 immediately; after release no trig until new edge; subsequent row 0x1FF writes 0x1FF0..0x1FFF.
REQ-037 Spurious done pulse in IDLE and in ISSUE -> ignored, k unchanged, trig count unchanged.
